// File: rtl/apb_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_cmd_master
//
// Purpose:
//   APB requester sitting directly in front of the UART APB slave. Takes a
//   valid/ready command stream (write DIVxR at addr 1, push a TX byte at
//   addr 2, pop an RX byte on read) and turns each command into one APB
//   SETUP/ACCESS transfer. The outcome (read data, slave error, timeout) is
//   returned on a valid/ready response channel. Only one transfer is ever
//   outstanding.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      command handshake
//   req_write/addr/wdata     command fields (wdata unused for reads)
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata/err/timeout    response fields
//   PADDR/PWRITE/PWDATA      APB request fields
//   PSEL/PENABLE             APB phase controls
//   PREADY/PSLVERR/PRDATA    APB completion, error and read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module apb_cmd_master #(
   parameter int APB_AW  = 8,
   parameter int APB_DW  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [APB_AW-1:0] req_addr,
   input  logic [APB_DW-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [APB_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [APB_AW-1:0] PADDR,
   output logic              PWRITE,
   output logic [APB_DW-1:0] PWDATA,
   output logic              PSEL,
   output logic              PENABLE,
   input  logic              PREADY,
   input  logic              PSLVERR,
   input  logic [APB_DW-1:0] PRDATA
);

   // Timer must be able to hold the value TIMEOUT (saturation point); keep
   // at least one bit so the TIMEOUT==0 build still elaborates.
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t            r_state;
   logic [TW-1:0]     r_timer;
   logic [APB_AW-1:0] r_paddr;
   logic              r_pwrite;
   logic [APB_DW-1:0] r_pwdata;
   logic              r_psel;
   logic              r_penable;
   logic              r_rsp_valid;
   logic [APB_DW-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_rsp_timeout;

   logic              w_timeout;

   // The timer holds k-1 during the k-th ACCESS cycle, so TO_LAST marks the
   // TIMEOUT-th cycle. PREADY in that same cycle wins over the abort.
   assign w_timeout = (TIMEOUT != 0) && (r_timer == TO_LAST) && !PREADY;

   // Combinational decode; gated by rst so nothing is accepted during reset.
   assign req_ready = (r_state == ST_IDLE) && rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_timer       <= '0;
         r_paddr       <= '0;
         r_pwrite      <= 1'b0;
         r_pwdata      <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_paddr   <= req_addr;
                  r_pwrite  <= req_write;
                  r_pwdata  <= req_wdata;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
                  r_state   <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               r_penable <= 1'b1;
               r_timer   <= '0;
               r_state   <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if ((TIMEOUT != 0) && (r_timer != TO_MAX)) begin
                  r_timer <= r_timer + TW'(1);
               end
               if (PREADY) begin
                  r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                  r_rsp_err     <= PSLVERR;
                  r_rsp_timeout <= 1'b0;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= ST_RESP;
               end else if (w_timeout) begin
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= ST_RESP;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign PADDR       = r_paddr;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps

module tb_apb_cmd_master;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          rsp_timeout;
   logic [AW-1:0] PADDR;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic          PSEL;
   logic          PENABLE;
   logic          PREADY;
   logic          PSLVERR;
   logic [DW-1:0] PRDATA;

   always #5 clk = ~clk;

   apb_cmd_master #(.APB_AW(AW), .APB_DW(DW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PADDR       (PADDR),
      .PWRITE      (PWRITE),
      .PWDATA      (PWDATA),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .PRDATA      (PRDATA)
   );

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
      logic          tmo;
   } rsp_t;

   rsp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Response monitor: handshake completes on the next rising edge.
   always @(negedge clk) begin
      rsp_t e;
      if (rst && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(sb.size()), 1);
         end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_timeout", rsp_timeout, e.tmo);
         end
      end
   end

   function automatic rsp_t model(input logic w, input int wait_n, input logic [DW-1:0] prd,
                                  input logic slv);
      rsp_t r;
      r.tmo   = (wait_n >= TO);
      r.rdata = (w || r.tmo) ? '0 : prd;
      r.err   = r.tmo | slv;
      return r;
   endfunction

   // Present a command and wait (bounded) for acceptance; ends in SETUP.
   task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit push, input rsp_t e, output int waited);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      if (push) sb.push_back(e);
      waited = 0;
      while (!req_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("setup_psel", PSEL, 1);
      chk("setup_penable", PENABLE, 0);
      chk("setup_paddr", PADDR, a);
      chk("setup_pwrite", PWRITE, w);
      chk("setup_pwdata", PWDATA, d);
   endtask

   // Slave model: PREADY in ACCESS cycle wait_n+1; garbage and PSLVERR=1
   // while not ready. Counts PSEL/PENABLE cycles including SETUP.
   task automatic access(input int wait_n, input logic [DW-1:0] prd, input logic slv,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int psel_n, output int pen_n);
      psel_n = 1;
      pen_n  = 0;
      @(posedge clk); #1;
      for (int i = 1; i <= 40; i++) begin
         if (!PSEL) break;
         psel_n++;
         if (PENABLE) pen_n++;
         if (PADDR !== a || PWDATA !== d) chk("access_hold", {PADDR, PWDATA}, {a, d});
         PREADY  = (i == wait_n + 1);
         PRDATA  = PREADY ? prd : 8'hEE;
         PSLVERR = PREADY ? slv : 1'b1;
         @(posedge clk); #1;
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      PRDATA  = '0;
   endtask

   // Hold rsp_ready low for 'hold' cycles, checking stability, then consume.
   task automatic finish_rsp(input int hold);
      logic [DW+1:0] snap;
      chk("rsp_valid", rsp_valid, 1);
      snap = {rsp_rdata, rsp_err, rsp_timeout};
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_stable", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, {1'b1, snap});
         chk("hold_req_ready", req_ready, 0);
         chk("hold_psel", PSEL, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("idle_ready", req_ready, 1);
   endtask

   task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int wait_n, input logic [DW-1:0] prd, input logic slv,
                       input int hold);
      rsp_t e;
      int   waited, ps, pe, exp_ps;
      e = model(w, wait_n, prd, slv);
      issue(w, a, d, 1'b1, e, waited);
      chk("accept_wait", waited, 0);
      access(wait_n, prd, slv, a, d, ps, pe);
      exp_ps = e.tmo ? (1 + TO) : (2 + wait_n);
      chk("psel_cycles", ps, exp_ps);
      chk("penable_cycles", pe, exp_ps - 1);
      finish_rsp(hold);
   endtask

   initial begin
      rsp_t e0;
      int   waited, ps, pe;
      logic rw, rs;
      logic [DW-1:0] rd, wd;
      int   rwait, rhold;

      rst = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      e0 = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_outputs", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, 0);
      chk("rst_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
      chk("rst_req_ready", req_ready, 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_ready", req_ready, 1);

      // 1: write, PREADY in 2nd ACCESS cycle; PRDATA must not leak into rdata
      xfer(1'b1, 8'h02, 8'h5A, 1, 8'h33, 1'b0, 0);
      chk("pwdata_kept", {PADDR, PWRITE, PWDATA}, {8'h02, 1'b1, 8'h5A});
      // 2: read, PREADY in 1st ACCESS cycle
      xfer(1'b0, 8'h00, 8'h00, 0, 8'hA5, 1'b0, 0);
      // 3: slave error on completion; PSLVERR while waiting ignored
      xfer(1'b0, 8'h00, 8'h11, 2, 8'h77, 1'b1, 0);
      xfer(1'b0, 8'h00, 8'h22, 3, 8'h3C, 1'b0, 1);
      xfer(1'b1, 8'h01, 8'h0F, 0, 8'h00, 1'b1, 0);
      // 4: timeout, and PREADY exactly in the last cycle
      xfer(1'b0, 8'h00, 8'h00, 100, 8'h99, 1'b0, 0);
      xfer(1'b0, 8'h00, 8'h00, TO - 1, 8'hC3, 1'b0, 0);
      xfer(1'b1, 8'h02, 8'h81, TO - 2, 8'h00, 1'b0, 0);

      // 5: response back-pressure with a second command pending
      e0 = model(1'b1, 0, 8'h00, 1'b0);
      issue(1'b1, 8'h01, 8'h40, 1'b1, e0, waited);
      access(0, 8'h00, 1'b0, 8'h01, 8'h40, ps, pe);
      req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'hF0; req_valid = 1'b1;
      finish_rsp(5);
      e0 = model(1'b0, 1, 8'h6B, 1'b0);
      issue(1'b0, 8'h00, 8'hF0, 1'b1, e0, waited);
      chk("second_accept_wait", waited, 0);
      access(1, 8'h6B, 1'b0, 8'h00, 8'hF0, ps, pe);
      chk("second_psel_cycles", ps, 3);
      finish_rsp(0);

      // 6: asynchronous reset during ACCESS, transfer dropped
      issue(1'b1, 8'h10, 8'h99, 1'b0, e0, waited);
      @(posedge clk); #1;
      chk("pre_rst_penable", PENABLE, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_psel_penable", {PSEL, PENABLE}, 0);
      chk("arst_rsp_valid", rsp_valid, 0);
      chk("arst_req_ready", req_ready, 0);
      chk("arst_paddr", PADDR, 0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_req_ready", req_ready, 1);
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("no_stale_rsp", rsp_valid, 0);
      xfer(1'b0, 8'h00, 8'h00, 1, 8'hD2, 1'b0, 0);

      // a few mixed transfers
      for (int k = 0; k < 4; k++) begin
         rw    = 1'($urandom_range(0, 1));
         rs    = 1'($urandom_range(0, 1));
         rd    = 8'($urandom_range(0, 255));
         wd    = 8'($urandom_range(0, 255));
         rwait = $urandom_range(0, 4);
         rhold = $urandom_range(0, 2);
         xfer(rw, rw ? 8'h02 : 8'h00, wd, rwait, rd, rs, rhold);
      end

      repeat (2) @(posedge clk);
      chk("sb_drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
